// File: rtl/compressor_pkg.sv
// Sizing helpers for the pipelined 3:2 compressor tree.
package compressor_pkg;

    // Terms left after one 3:2 level: each full group of three yields two.
    function automatic int unsigned num_results(input int unsigned n);
        return 32'd2 * (n / 32'd3) + (n % 32'd3);
    endfunction

    // Number of 3:2 levels needed to reach two (or fewer) terms.
    function automatic int unsigned num_levels(input int unsigned n);
        int unsigned k;
        int unsigned cnt;
        k   = n;
        cnt = 0;
        while (k > 32'd2) begin
            k   = num_results(k);
            cnt = cnt + 32'd1;
        end
        return cnt;
    endfunction

    // Number of terms entering level lvl.
    function automatic int unsigned terms_at_level(input int unsigned n, input int unsigned lvl);
        int unsigned k;
        k = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            k = num_results(k);
        end
        return k;
    endfunction

    // Accepted input to out_valid, in cycles, with no stall.
    function automatic int unsigned pipe_latency(input int unsigned n, input int unsigned lps);
        return (num_levels(n) + lps - 32'd1) / lps + 32'd1;
    endfunction

endpackage

// File: rtl/csa_reduce_level.sv
// One combinational 3:2 carry-save reduction level.
module csa_reduce_level
    import compressor_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned BIT_LEN = 16
) (
    input  logic [BIT_LEN-1:0] in_terms  [N],
    output logic [BIT_LEN-1:0] out_terms [num_results(N)]
);

    localparam int unsigned GROUPS = N / 3;
    localparam int unsigned REM    = N % 3;

    // Full adders per group of three: sum bit in place, majority shifted up one.
    for (genvar g = 0; g < GROUPS; g++) begin : g_fa
        logic [BIT_LEN-1:0] a;
        logic [BIT_LEN-1:0] b;
        logic [BIT_LEN-1:0] c;
        logic [BIT_LEN-1:0] maj;
        assign a   = in_terms[3*g];
        assign b   = in_terms[3*g+1];
        assign c   = in_terms[3*g+2];
        assign maj = (a & b) | (a & c) | (b & c);
        assign out_terms[2*g]   = a ^ b ^ c;
        assign out_terms[2*g+1] = maj << 1;
    end

    // Leftover one or two terms pass straight through.
    for (genvar r = 0; r < REM; r++) begin : g_pass
        assign out_terms[2*GROUPS+r] = in_terms[3*GROUPS+r];
    end

endmodule

// File: rtl/pipelined_compressor_tree.sv
// Pipelined carry-save adder tree with valid/ready flow control and tag sideband.
module pipelined_compressor_tree
    import compressor_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS     = 9,
    parameter int unsigned BIT_LEN          = 16,
    parameter int unsigned LEVELS_PER_STAGE = 2,
    parameter int unsigned TAG_W            = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_LEN-1:0]  terms [NUM_ELEMENTS],
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIT_LEN-1:0]  out_sum,
    output logic [BIT_LEN-1:0]  out_s,
    output logic [BIT_LEN-1:0]  out_c,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int unsigned L = num_levels(NUM_ELEMENTS);
    localparam int unsigned S = pipe_latency(NUM_ELEMENTS, LEVELS_PER_STAGE) - 1;

    logic               adv;
    logic               accept;
    logic               last_valid;
    logic [TAG_W-1:0]   last_tag;
    logic [BIT_LEN-1:0] fin_s;
    logic [BIT_LEN-1:0] fin_c;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    if (S > 0) begin : g_ctl
        logic             stg_valid [S];
        logic [TAG_W-1:0] stg_tag   [S];

        // Valid and tag shift register, one entry per data stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < S; s++) begin
                    stg_valid[s] <= 1'b0;
                    stg_tag[s]   <= '0;
                end
            end else if (adv) begin
                stg_valid[0] <= accept;
                stg_tag[0]   <= in_tag;
                for (int unsigned s = 1; s < S; s++) begin
                    stg_valid[s] <= stg_valid[s-1];
                    stg_tag[s]   <= stg_tag[s-1];
                end
            end
        end

        assign last_valid = stg_valid[S-1];
        assign last_tag   = stg_tag[S-1];
    end else begin : g_noctl
        assign last_valid = accept;
        assign last_tag   = in_tag;
    end

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int unsigned N_IN  = terms_at_level(NUM_ELEMENTS, l);
        localparam int unsigned N_OUT = num_results(N_IN);
        localparam bit          REG   = ((l + 1) % LEVELS_PER_STAGE == 0) || (l + 1 == L);

        logic [BIT_LEN-1:0] lin  [N_IN];
        logic [BIT_LEN-1:0] lout [N_OUT];
        logic [BIT_LEN-1:0] nxt  [N_OUT];

        if (l == 0) begin : g_src
            assign lin = terms;
        end else begin : g_src
            assign lin = g_lvl[l-1].nxt;
        end

        csa_reduce_level #(
            .N       (N_IN),
            .BIT_LEN (BIT_LEN)
        ) u_level (
            .in_terms  (lin),
            .out_terms (lout)
        );

        if (REG) begin : g_reg
            // Stage data register; bubbles may carry stale data.
            always_ff @(posedge clk) begin
                if (adv) begin
                    nxt <= lout;
                end
            end
        end else begin : g_comb
            assign nxt = lout;
        end
    end

    if (L == 0) begin : g_fin
        assign fin_s = terms[0];
        if (NUM_ELEMENTS > 1) begin : g_two
            assign fin_c = terms[1];
        end else begin : g_one
            assign fin_c = '0;
        end
    end else begin : g_fin
        assign fin_s = g_lvl[L-1].nxt[0];
        assign fin_c = g_lvl[L-1].nxt[1];
    end

    // Output register after the final carry-propagate add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_s     <= '0;
            out_c     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= last_valid;
            out_sum   <= fin_s + fin_c;
            out_s     <= fin_s;
            out_c     <= fin_c;
            out_tag   <= last_tag;
        end
    end

endmodule

// File: tb/tb_pipelined_compressor_tree.sv
// Randomized and directed bench for pipelined_compressor_tree against a slot model.
module tb_pipelined_compressor_tree;

    localparam int unsigned N   = 9;
    localparam int unsigned B   = 16;
    localparam int unsigned TW  = 4;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [B-1:0]  terms [N];
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [B-1:0]  out_sum;
    logic [B-1:0]  out_s;
    logic [B-1:0]  out_c;
    logic [TW-1:0] out_tag;

    logic          in_valid1, in_ready1, out_valid1;
    logic [B-1:0]  terms1 [1];
    logic [B-1:0]  out_sum1, out_s1, out_c1;
    logic [TW-1:0] out_tag1;
    logic          in_valid2, in_ready2, out_valid2;
    logic [B-1:0]  terms2 [2];
    logic [B-1:0]  out_sum2, out_s2, out_c2;
    logic [TW-1:0] out_tag2;
    logic          ready_hi = 1'b1;
    logic [TW-1:0] tag_zero = '0;

    always #5 clk = ~clk;

    pipelined_compressor_tree #(.NUM_ELEMENTS(N), .BIT_LEN(B), .LEVELS_PER_STAGE(2), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .terms(terms),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_s(out_s), .out_c(out_c), .out_tag(out_tag));

    pipelined_compressor_tree #(.NUM_ELEMENTS(1), .BIT_LEN(B), .LEVELS_PER_STAGE(2), .TAG_W(TW)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .terms(terms1),
        .in_tag(tag_zero), .out_valid(out_valid1), .out_ready(ready_hi), .out_sum(out_sum1),
        .out_s(out_s1), .out_c(out_c1), .out_tag(out_tag1));

    pipelined_compressor_tree #(.NUM_ELEMENTS(2), .BIT_LEN(B), .LEVELS_PER_STAGE(2), .TAG_W(TW)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .terms(terms2),
        .in_tag(tag_zero), .out_valid(out_valid2), .out_ready(ready_hi), .out_sum(out_sum2),
        .out_s(out_s2), .out_c(out_c2), .out_tag(out_tag2));

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model: LAT slots, the last of which is the visible output.
    bit            mv [LAT];
    logic [B-1:0]  ms [LAT];
    logic [TW-1:0] mt [LAT];
    logic [B-1:0]  stim [N];
    logic [B-1:0]  got_sum [$];
    logic [TW-1:0] got_tag [$];
    int unsigned   n_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < LAT; k++) begin
            mv[k] = 1'b0;
            ms[k] = '0;
            mt[k] = '0;
        end
    endtask

    // One cycle: drive on negedge, step the model on posedge, compare just after.
    task automatic step(input bit v, input bit ordy, input logic [TW-1:0] tg);
        bit           madv;
        int unsigned  acc;
        logic [B-1:0] pair;
        @(negedge clk);
        in_valid  = v;
        in_tag    = tg;
        out_ready = ordy;
        terms     = stim;
        #1;
        if (out_valid && ordy) begin
            got_sum.push_back(out_sum);
            got_tag.push_back(out_tag);
        end
        madv = !mv[LAT-1] || ordy;
        check("in_ready", 32'(in_ready), 32'(madv));
        acc = 0;
        for (int i = 0; i < N; i++) acc = acc + 32'(stim[i]);
        @(posedge clk);
        if (madv) begin
            for (int k = LAT - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                ms[k] = ms[k-1];
                mt[k] = mt[k-1];
            end
            mv[0] = v;
            ms[0] = B'(acc % 32'h10000);
            mt[0] = tg;
            if (v) n_acc++;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(mv[LAT-1]));
        if (mv[LAT-1]) begin
            pair = out_s + out_c;
            check("out_sum", 32'(out_sum), 32'(ms[LAT-1]));
            check("out_tag", 32'(out_tag), 32'(mt[LAT-1]));
            check("s_plus_c", 32'(pair), 32'(ms[LAT-1]));
        end
    endtask

    task automatic fill(input logic [B-1:0] val);
        for (int i = 0; i < N; i++) stim[i] = val;
    endtask

    initial begin
        logic [B-1:0] frozen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_tag = '0;
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        terms1[0] = '0; terms2[0] = '0; terms2[1] = '0;
        fill('0); terms = stim;
        model_clear(); n_acc = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All ones: first result after three cycles.
        fill(B'(1));
        step(1'b1, 1'b1, 4'h5);
        fill('0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        check("ones_valid", 32'(out_valid), 32'd1);
        check("ones_sum", 32'(out_sum), 32'd9);
        check("ones_tag", 32'(out_tag), 32'd5);

        // All 0xFFFF wraps.
        fill(16'hFFFF);
        step(1'b1, 1'b1, 4'h3);
        fill('0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        check("wrap_sum", 32'(out_sum), 32'h0000FFF7);
        step(1'b0, 1'b1, 4'h0);

        // Ten back-to-back transactions.
        got_sum.delete(); got_tag.delete();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) stim[i] = B'(k + i);
            step(1'b1, 1'b1, TW'(k));
        end
        fill('0);
        repeat (4) step(1'b0, 1'b1, 4'h0);
        check("stream_count", got_sum.size(), 32'd10);
        for (int k = 0; k < 10 && k < got_sum.size(); k++) begin
            check("stream_sum", 32'(got_sum[k]), 32'(9 * k + 36));
            check("stream_tag", 32'(got_tag[k]), 32'(k));
        end

        // Stall with a full pipeline, then resume.
        got_sum.delete(); got_tag.delete(); n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            fill(B'(100 + k));
            step(1'b1, 1'b1, TW'(k + 1));
        end
        frozen = out_sum;
        for (int k = 0; k < 5; k++) begin
            fill(B'(200 + k));
            step(1'b1, 1'b0, TW'(k + 8));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        check("stall_frozen", 32'(out_sum), 32'(frozen));
        fill('0);
        repeat (5) step(1'b0, 1'b1, 4'h0);
        check("stall_count", got_sum.size(), n_acc);

        // Reset with transactions in flight.
        for (int k = 0; k < 3; k++) begin
            fill(B'(k + 1));
            step(1'b1, 1'b1, TW'(k));
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        got_sum.delete(); got_tag.delete();
        fill('0);
        repeat (5) step(1'b0, 1'b1, 4'h0);
        check("midrst_no_results", got_sum.size(), 32'd0);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) stim[i] = B'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, TW'($urandom));
        end
        fill('0);
        repeat (5) step(1'b0, 1'b1, 4'h0);

        // Single- and two-operand instances.
        @(negedge clk);
        in_valid1 = 1'b1; terms1[0] = 16'd7;
        in_valid2 = 1'b1; terms2[0] = 16'd3; terms2[1] = 16'd4;
        #1;
        check("n1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        check("n1_valid", 32'(out_valid1), 32'd1);
        check("n1_sum", 32'(out_sum1), 32'd7);
        check("n2_valid", 32'(out_valid2), 32'd1);
        check("n2_sum", 32'(out_sum2), 32'd7);
        @(negedge clk);
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        @(posedge clk); #1;
        check("n1_idle", 32'(out_valid1), 32'd0);
        check("n2_idle", 32'(out_valid2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
